// File: rtl/key_result_arbiter.sv
// ---------------------------------------------------------------------------
// key_result_arbiter
//
// Collects per-core results from NUM_CORES parallel RC4 key-search cores.
// It latches the first successful key for the HEX display. When several
// cores succeed in the same cycle, the lowest index wins. It drives a
// broadcast stop to all cores once a search ends. It reports failure when
// every core has exhausted its key range without a success.
//
// Optional feature: define KEY_ARB_CYCLE_COUNT_EN to add the search_cycles
// counter and port.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   start         1-cycle pulse that begins a new search (ignored in SEARCH)
//   clear         return to IDLE and clear the latched result (beats start)
//   core_success  bit i: core i holds a valid key
//   core_done     bit i: core i exhausted its range
//   core_key      core i key at [i*KEY_WIDTH +: KEY_WIDTH]
//   busy          high in SEARCH
//   stop_cores    high in FOUND and FAILED
//   found         high in FOUND
//   failed        high in FAILED
//   success_state one-hot winner, 0 when there is no winner
//   winner_idx    binary winner index
//   secret_key    latched winning key, 0 when there is no winner
//   search_cycles clocks spent in SEARCH, saturating (KEY_ARB_CYCLE_COUNT_EN)
// ---------------------------------------------------------------------------
module key_result_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24,
  parameter int CNT_WIDTH = 32,
  localparam int WIDX = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           clear,
  input  logic [NUM_CORES-1:0]           core_success,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic                           busy,
  output logic                           stop_cores,
  output logic                           found,
  output logic                           failed,
  output logic [NUM_CORES-1:0]           success_state,
  output logic [WIDX-1:0]                winner_idx,
`ifdef KEY_ARB_CYCLE_COUNT_EN
  output logic [CNT_WIDTH-1:0]           search_cycles,
`endif
  output logic [KEY_WIDTH-1:0]           secret_key
);

  if (NUM_CORES < 1) begin : g_bad_num_cores
    $error("NUM_CORES must be >= 1");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FOUND  = 2'd2,
    FAILED = 2'd3
  } state_t;

  // Lowest set bit wins. The scan runs from the top down so that the last
  // assignment is the lowest index.
  function automatic logic [WIDX-1:0] lowest_idx(input logic [NUM_CORES-1:0] v);
    logic [WIDX-1:0] idx;
    idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (v[i]) idx = WIDX'(i);
    end
    return idx;
  endfunction

  state_t               state, state_nxt;
  logic [NUM_CORES-1:0] done_mask, done_mask_nxt;
  logic [NUM_CORES-1:0] done_all;
  logic [WIDX-1:0]      win_idx;
  logic                 latch_win;
  logic                 clr_result;

  assign win_idx = lowest_idx(core_success);

  always_comb begin
    state_nxt     = state;
    done_mask_nxt = done_mask;
    latch_win     = 1'b0;
    clr_result    = 1'b0;
    done_all      = done_mask | core_done;
    if (clear) begin
      state_nxt     = IDLE;
      clr_result    = 1'b1;
      done_mask_nxt = '0;
    end else begin
      case (state)
        IDLE, FOUND, FAILED: begin
          if (start) begin
            state_nxt     = SEARCH;
            clr_result    = 1'b1;
            done_mask_nxt = '0;
          end
        end
        SEARCH: begin
          done_mask_nxt = done_all;
          // A success beats a simultaneous final done, and a core that has
          // already reported done may still deliver a key.
          if (|core_success) begin
            state_nxt = FOUND;
            latch_win = 1'b1;
          end else if (&done_all) begin
            state_nxt = FAILED;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status flags are registered from the next state, so they line up with
  // the state change and are not decoded from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      done_mask  <= '0;
      busy       <= 1'b0;
      stop_cores <= 1'b0;
      found      <= 1'b0;
      failed     <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_mask  <= done_mask_nxt;
      busy       <= (state_nxt == SEARCH);
      stop_cores <= (state_nxt == FOUND) || (state_nxt == FAILED);
      found      <= (state_nxt == FOUND);
      failed     <= (state_nxt == FAILED);
    end
  end

  // The winning result is captured on the edge that samples the success.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      success_state <= '0;
      winner_idx    <= '0;
      secret_key    <= '0;
    end else if (clr_result) begin
      success_state <= '0;
      winner_idx    <= '0;
      secret_key    <= '0;
    end else if (latch_win) begin
      success_state <= NUM_CORES'(1) << win_idx;
      winner_idx    <= win_idx;
      secret_key    <= core_key[int'(win_idx)*KEY_WIDTH +: KEY_WIDTH];
    end
  end

`ifdef KEY_ARB_CYCLE_COUNT_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // The counter increments on every edge taken while in SEARCH, including the
  // edge that leaves it. Start and clear reset the counter to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      search_cycles <= '0;
    end else if (clr_result) begin
      search_cycles <= '0;
    end else if (state == SEARCH) begin
      search_cycles <= sat_inc(search_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_key_result_arbiter.sv
module tb_key_result_arbiter;

  localparam int NC = 4;
  localparam int KW = 24;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, clear;
  logic [NC-1:0]    core_success, core_done;
  logic [KW-1:0]    keys [NC];
  logic [NC*KW-1:0] core_key;
  logic             busy, stop_cores, found, failed;
  logic [NC-1:0]    success_state;
  logic [1:0]       winner_idx;
  logic [KW-1:0]    secret_key;
`ifdef KEY_ARB_CYCLE_COUNT_EN
  logic [CW-1:0]    search_cycles;
`endif

  assign core_key = {keys[3], keys[2], keys[1], keys[0]};

  always #5 clk = ~clk;

  key_result_arbiter #(.NUM_CORES(NC), .KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .clear        (clear),
    .core_success (core_success),
    .core_done    (core_done),
    .core_key     (core_key),
    .busy         (busy),
    .stop_cores   (stop_cores),
    .found        (found),
    .failed       (failed),
    .success_state(success_state),
    .winner_idx   (winner_idx),
`ifdef KEY_ARB_CYCLE_COUNT_EN
    .search_cycles(search_cycles),
`endif
    .secret_key   (secret_key)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model. phase: 0 idle, 1 searching, 2 found, 3 failed.
  int            m_phase;
  logic [NC-1:0] m_mask, m_ss;
  logic [1:0]    m_wi;
  logic [KW-1:0] m_key;
  int            m_cnt;

  task automatic model_reset();
    m_phase = 0; m_mask = '0; m_ss = '0; m_wi = '0; m_key = '0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int w;
    if (reset || clear) begin
      model_reset();
      return;
    end
    if (m_phase == 1) begin
      if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      m_mask = m_mask | core_done;
      if (core_success != 0) begin
        w = -1;
        for (int i = 0; i < NC; i++) if (w < 0 && core_success[i]) w = i;
        m_phase = 2;
        m_wi    = 2'(w);
        m_ss    = NC'(1 << w);
        m_key   = keys[w];
      end else if (m_mask == '1) begin
        m_phase = 3;
      end
    end else if (start) begin
      m_phase = 1; m_mask = '0; m_ss = '0; m_wi = '0; m_key = '0; m_cnt = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".busy"},   busy,       m_phase == 1);
    check({tag, ".stop"},   stop_cores, m_phase >= 2);
    check({tag, ".found"},  found,      m_phase == 2);
    check({tag, ".failed"}, failed,     m_phase == 3);
    check({tag, ".ss"},     success_state, m_ss);
    check({tag, ".widx"},   winner_idx, m_wi);
    check({tag, ".key"},    secret_key, m_key);
`ifdef KEY_ARB_CYCLE_COUNT_EN
    check({tag, ".cnt"},    search_cycles, m_cnt);
`endif
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic cyc(input string tag, input logic st, input logic cl,
                     input logic [NC-1:0] su, input logic [NC-1:0] dn);
    start = st; clear = cl; core_success = su; core_done = dn;
    step(tag);
    start = 1'b0; clear = 1'b0; core_success = '0; core_done = '0;
  endtask

  task automatic reset_mid(input string tag);
    reset = 1'b1;
    #2;
    model_reset();
    compare_all({tag, ".async"});
    step({tag, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; clear = 0; core_success = '0; core_done = '0;
    for (int i = 0; i < NC; i++) keys[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    reset = 1'b0;

    // 1: single success after 5 clocks
    keys[0] = 24'h000AAA; keys[1] = 24'h000BBB; keys[2] = 24'h00ABCD; keys[3] = 24'h000DDD;
    cyc("t1.start", 1, 0, 4'b0000, 4'b0000);
    check("t1.busy_after_start", busy, 1);
    for (int i = 0; i < 5; i++) cyc("t1.wait", 0, 0, 4'b0000, 4'b0000);
    cyc("t1.hit", 0, 0, 4'b0100, 4'b0000);
    check("t1.found", found, 1);
    check("t1.stop", stop_cores, 1);
    check("t1.ss", success_state, 4'b0100);
    check("t1.widx", winner_idx, 2);
    check("t1.key", secret_key, 24'h00ABCD);
    cyc("t1.ignore", 0, 0, 4'b0001, 4'b1111);
    check("t1.held_key", secret_key, 24'h00ABCD);

    // 2: tie goes to the lowest index
    keys[1] = 24'h000111; keys[3] = 24'h000333;
    cyc("t2.start", 1, 0, 4'b0000, 4'b0000);
    check("t2.key_cleared", secret_key, 0);
    cyc("t2.hit", 0, 0, 4'b1010, 4'b0000);
    check("t2.widx", winner_idx, 1);
    check("t2.ss", success_state, 4'b0010);
    check("t2.key", secret_key, 24'h000111);

    // 3: all cores exhausted without success
    cyc("t3.start", 1, 0, 4'b0000, 4'b0000);
    cyc("t3.d0", 0, 0, 4'b0000, 4'b0001);
    cyc("t3.d1", 0, 0, 4'b0000, 4'b0100);
    check("t3.not_yet", failed, 0);
    cyc("t3.d2", 0, 0, 4'b0000, 4'b1010);
    check("t3.failed", failed, 1);
    check("t3.key", secret_key, 0);
    check("t3.ss", success_state, 0);

    // 4: success in the same cycle as the final done
    cyc("t4.start", 1, 0, 4'b0000, 4'b0000);
    cyc("t4.d", 0, 0, 4'b0000, 4'b0111);
    cyc("t4.both", 0, 0, 4'b0010, 4'b1000);
    check("t4.found", found, 1);
    check("t4.failed", failed, 0);
    check("t4.widx", winner_idx, 1);

    // 5: async reset mid-search, restart from FOUND, clear beats start
    cyc("t5.start", 1, 0, 4'b0000, 4'b0000);
    cyc("t5.d", 0, 0, 4'b0000, 4'b0011);
    reset_mid("t5.rst");
    check("t5.busy_rst", busy, 0);
    cyc("t5.start2", 1, 0, 4'b0000, 4'b0000);
    cyc("t5.hit", 0, 0, 4'b1000, 4'b0000);
    check("t5.found", found, 1);
    cyc("t5.restart", 1, 0, 4'b0000, 4'b0000);
    check("t5.busy", busy, 1);
    check("t5.found0", found, 0);
    check("t5.key0", secret_key, 0);
    cyc("t5.hit2", 0, 0, 4'b0001, 4'b0000);
    cyc("t5.clr_start", 1, 1, 4'b0000, 4'b0000);
    check("t5.idle_busy", busy, 0);
    check("t5.idle_found", found, 0);

`ifdef KEY_ARB_CYCLE_COUNT_EN
    // 6: cycle counter, success sampled 7 clocks after start
    cyc("t6.start", 1, 0, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) cyc("t6.wait", 0, 0, 4'b0000, 4'b0000);
    cyc("t6.hit", 0, 0, 4'b0001, 4'b0000);
    check("t6.cnt", search_cycles, 7);
    for (int i = 0; i < 3; i++) cyc("t6.hold", 0, 0, 4'b0000, 4'b0000);
    check("t6.cnt_held", search_cycles, 7);
    cyc("t6.restart", 1, 0, 4'b0000, 4'b0000);
    check("t6.cnt_clr", search_cycles, 0);
    for (int i = 0; i < 20; i++) cyc("t6.sat", 0, 0, 4'b0000, 4'b0000);
    check("t6.cnt_sat", search_cycles, 15);
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [NC-1:0] su, dn;
      for (int i = 0; i < NC; i++) keys[i] = KW'($urandom);
      su = ($urandom_range(0, 19) == 0) ? NC'($urandom) : '0;
      dn = '0;
      for (int i = 0; i < NC; i++) dn[i] = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 199) == 0) begin
        reset_mid("rnd.rst");
      end else begin
        cyc("rnd", ($urandom_range(0, 5) == 0), ($urandom_range(0, 79) == 0), su, dn);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
